twiddle_sequencer: RTL and testbench

Parametrised radix-2 FFT twiddle source for the FFT datapath: it holds a quarter-wave cosine table and emits the twiddle sequence for one butterfly stage on a ready/valid stream. It replaces the fixed 32-entry twiddle lookup. Point count, word width and fraction width are generic. It also adds forward/inverse mode (conjugated twiddles for IFFT) and per-stage stride addressing. It sits between the FFT stage controller (start, stage, inverse) and the butterfly unit (stream consumer).

---
 rtl/twiddle_pkg.sv | 25 ++
 rtl/twiddle_quarter_rom.sv | 38 +++
 rtl/twiddle_sequencer.sv | 137 +++++++++++++
 tb/tb_twiddle_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the FFT twiddle source.
package twiddle_pkg;

  localparam int  TW_W = 16;
  localparam real PI   = 3.14159265358979323846;

  // Container for one twiddle at the default word width.
  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } twiddle_t;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  // Q[i] = round(cos(2*pi*i/n) * 2^frac_w). All entries are non-negative,
  // so rounding is a plain +0.5 and truncate.
  function automatic int quarter_entry(input int n, input int frac_w, input int i);
    real v;
    v = $cos(2.0 * PI * real'(i) / real'(n)) * real'(1 << frac_w);
    return $rtoi(v + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table, N/4+1 entries, two registered read ports.
module twiddle_quarter_rom
  import twiddle_pkg::*;
#(
  parameter int  N_POINTS = 64,
  parameter int  DATA_W   = 16,
  parameter int  FRAC_W   = 14,
  localparam int DEPTH    = N_POINTS / 4 + 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic [ADDR_W-1:0]        addr_b,
  output logic signed [DATA_W-1:0] data_a,
  output logic signed [DATA_W-1:0] data_b
);

  logic signed [DATA_W-1:0] table_q [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    localparam int VALUE = quarter_entry(N_POINTS, FRAC_W, i);
    assign table_q[i] = DATA_W'(VALUE);
  end

  // enable low freezes both ports so a stalled pipeline keeps its read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_a <= '0;
      data_b <= '0;
    end else if (enable) begin
      data_a <= table_q[addr_a];
      data_b <= table_q[addr_b];
    end
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// Emits the radix-2 twiddle sequence of one FFT stage as a ready/valid stream
// through a 3-stage pipeline: counter/k mapping, table read, mirror/sign.
module twiddle_sequencer
  import twiddle_pkg::*;
#(
  parameter int  N_POINTS = 64,
  parameter int  DATA_W   = 16,
  parameter int  FRAC_W   = 14,
  localparam int LOG2N    = log2n(N_POINTS),
  localparam int STAGE_W  = $clog2(LOG2N),
  localparam int IDX_W    = LOG2N - 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [STAGE_W-1:0]       stage,
  input  logic                     inverse,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_real,
  output logic signed [DATA_W-1:0] out_imag,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last
);

  localparam logic [IDX_W-1:0] QUARTER = IDX_W'(N_POINTS / 4);

  // Stream handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both 1; while out_valid=1 and out_ready=0 every pipeline
  // stage holds, so the output word is stable until it is taken.
  logic advance;
  logic accept;
  logic issue;
  logic [IDX_W-1:0]   count;
  logic [STAGE_W-1:0] stage_q;
  logic               inverse_q;

  logic [IDX_W-1:0] mask, k, m, cos_addr, sin_addr;
  logic             mirror;

  logic             v0, last0, neg0;
  logic [IDX_W-1:0] idx0, cos_addr_q, sin_addr_q;
  logic             v1, last1, neg1;
  logic [IDX_W-1:0] idx1;
  logic signed [DATA_W-1:0] cos_d, sin_d;

  assign advance = !out_valid || out_ready;
  assign accept  = start && !busy && (int'(stage) < LOG2N);

  // k = (b mod 2^stage) << (LOG2N-1-stage); the top bit of k selects the
  // second quadrant, where cos is mirrored and negated.
  always_comb begin
    mask     = '0;
    k        = '0;
    m        = '0;
    mirror   = 1'b0;
    cos_addr = '0;
    sin_addr = '0;
    mask     = IDX_W'((32'd1 << stage_q) - 32'd1);
    k        = (count & mask) << (STAGE_W'(IDX_W) - stage_q);
    mirror   = k[IDX_W-1];
    m        = {1'b0, k[IDX_W-2:0]};
    cos_addr = mirror ? QUARTER - m : k;
    sin_addr = mirror ? m : QUARTER - k;
  end

  twiddle_quarter_rom #(
    .N_POINTS(N_POINTS),
    .DATA_W  (DATA_W),
    .FRAC_W  (FRAC_W)
  ) u_rom (
    .clock (clock),
    .reset (reset),
    .enable(advance),
    .addr_a(cos_addr_q),
    .addr_b(sin_addr_q),
    .data_a(cos_d),
    .data_b(sin_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      issue      <= 1'b0;
      count      <= '0;
      stage_q    <= '0;
      inverse_q  <= 1'b0;
      v0         <= 1'b0;
      last0      <= 1'b0;
      neg0       <= 1'b0;
      idx0       <= '0;
      cos_addr_q <= '0;
      sin_addr_q <= '0;
      v1         <= 1'b0;
      last1      <= 1'b0;
      neg1       <= 1'b0;
      idx1       <= '0;
      out_valid  <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
    end else begin
      if (out_valid && out_ready && out_last) busy <= 1'b0;
      if (advance) begin
        if (issue) begin
          count <= count + 1'b1;
          if (count == '1) issue <= 1'b0;
        end
        v0         <= issue;
        idx0       <= count;
        last0      <= (count == '1);
        neg0       <= mirror;
        cos_addr_q <= cos_addr;
        sin_addr_q <= sin_addr;
        v1         <= v0;
        idx1       <= idx0;
        last1      <= last0;
        neg1       <= neg0;
        out_valid  <= v1;
        out_index  <= v1 ? idx1 : '0;
        out_last   <= v1 && last1;
        out_real   <= !v1 ? '0 : (neg1 ? -cos_d : cos_d);
        out_imag   <= !v1 ? '0 : (inverse_q ? sin_d : -sin_d);
      end
      if (accept) begin
        busy      <= 1'b1;
        issue     <= 1'b1;
        count     <= '0;
        stage_q   <= stage;
        inverse_q <= inverse;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_sequencer.sv
// Directed-step bench for twiddle_sequencer with a trig-based reference model.
module tb_twiddle_sequencer;
  import twiddle_pkg::*;

  localparam int N  = 64;
  localparam int WW = 2 * TW_W + 5 + 1;

  logic clock, reset, start, inverse, out_ready;
  logic [2:0] stage;
  logic busy, out_valid, out_last;
  logic signed [15:0] out_real, out_imag;
  logic [4:0] out_index;

  int vectors = 0;
  int miscompares = 0;
  logic [WW-1:0] exp_q[$];
  logic signed [15:0] rx_real [32];
  logic signed [15:0] rx_imag [32];

  twiddle_sequencer #(.N_POINTS(N), .DATA_W(16), .FRAC_W(14)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stage    (stage),
    .inverse  (inverse),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_real (out_real),
    .out_imag (out_imag),
    .out_index(out_index),
    .out_last (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [63:0] observed,
                       input logic signed [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  // Reference: twiddle b uses angle 2*pi*k/N with k from the stride rule.
  task automatic build_expected(input int s, input bit inv);
    twiddle_t w;
    int j, k;
    real ang;
    exp_q.delete();
    for (int b = 0; b < N / 2; b++) begin
      j = b % (1 << s);
      k = j * (1 << (5 - s));
      ang = 2.0 * PI * real'(k) / real'(N);
      w.re = 16'(rnd($cos(ang) * 16384.0));
      w.im = 16'(inv ? rnd($sin(ang) * 16384.0) : -rnd($sin(ang) * 16384.0));
      exp_q.push_back({w, 5'(b), (b == N / 2 - 1)});
    end
  endtask

  task automatic run_stage(input int s, input bit inv, input int pct,
                           input int poke_cycle, input int poke_stage);
    int cycle, transfers, last_xfer;
    bit held, done;
    logic [WW-1:0] held_word, obs_word, exp_word;
    build_expected(s, inv);
    for (int i = 0; i < 32; i++) begin
      rx_real[i] = 'x;
      rx_imag[i] = 'x;
    end
    start = 1'b1;
    stage = 3'(s);
    inverse = inv;
    @(negedge clock);
    start = 1'b0;
    cycle = 0;
    transfers = 0;
    last_xfer = -1;
    held = 1'b0;
    done = 1'b0;
    held_word = '0;
    while (!done && cycle < 400) begin
      obs_word = {out_real, out_imag, out_index, out_last};
      if (pct >= 100) begin
        check("valid_timing", out_valid, (cycle >= 3 && cycle <= 34));
        check("busy_timing", busy, (cycle <= 34));
      end
      if (held) check("stall_hold", {out_valid, obs_word}, {1'b1, held_word});
      if (!busy && cycle > 0) begin
        done = 1'b1;
        check("busy_drop", cycle, last_xfer + 1);
      end else begin
        out_ready = ($urandom_range(99, 0) < pct);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("extra_word", 1, 0);
          else begin
            exp_word = exp_q.pop_front();
            check("word", obs_word, exp_word);
          end
          rx_real[out_index] = out_real;
          rx_imag[out_index] = out_imag;
          transfers++;
          last_xfer = cycle;
        end
        held = out_valid && !out_ready;
        held_word = obs_word;
        if (cycle == poke_cycle) begin
          start = 1'b1;
          stage = 3'(poke_stage);
        end else start = 1'b0;
        @(negedge clock);
        cycle++;
      end
    end
    start = 1'b0;
    check("sequence_done", done, 1);
    check("transfer_count", transfers, 32);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stage = '0;
    inverse = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_real", out_real, 0);
    check("rst_imag", out_imag, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    reset = 1'b0;
    @(negedge clock);

    run_stage(0, 1'b0, 100, -1, 0);
    check("s0_real31", rx_real[31], 16384);
    check("s0_imag31", rx_imag[31], 0);

    run_stage(5, 1'b0, 100, -1, 0);
    check("s5_real8", rx_real[8], 11585);
    check("s5_imag8", rx_imag[8], -11585);
    check("s5_real16", rx_real[16], 0);
    check("s5_imag16", rx_imag[16], -16384);
    check("s5_real24", rx_real[24], -11585);
    check("s5_imag24", rx_imag[24], -11585);
    check("s5_real31", rx_real[31], -16305);
    check("s5_imag31", rx_imag[31], -1606);

    // Start while busy must neither restart nor queue a second sequence.
    run_stage(5, 1'b1, 100, 10, 1);
    check("s5i_real16", rx_real[16], 0);
    check("s5i_imag16", rx_imag[16], 16384);
    check("s5i_real8", rx_real[8], 11585);
    check("s5i_imag8", rx_imag[8], 11585);
    check_idle("no_queued_start", 10);

    run_stage(2, 1'b0, 50, -1, 0);
    run_stage(3, 1'b1, 70, -1, 0);
    run_stage(4, 1'b0, 100, 20, 6);

    // Out-of-range stage while idle.
    start = 1'b1;
    stage = 3'd6;
    @(negedge clock);
    start = 1'b0;
    check_idle("stage6_ignored", 10);

    // Reset mid-sequence clears outputs without waiting for a clock edge.
    start = 1'b1;
    stage = 3'd5;
    inverse = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    check("pre_abort_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_real", out_real, 0);
    check("abort_imag", out_imag, 0);
    check("abort_index", out_index, 0);
    check("abort_last", out_last, 0);
    @(negedge clock);
    reset = 1'b0;
    check_idle("idle_after_reset", 100);

    run_stage(1, 1'b1, 100, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
